// File: rtl/mips_memory_arbiter.sv
// Single-port memory arbiter between the fetch stage and the mem stage.
// One access is in flight at a time; read data returns with a one-cycle
// rvalid pulse on the owning port. Data wins arbitration unless fetch has
// been starved for STARVE_LIMIT consecutive cycles.
package mips_memory_arbiter_pkg;
    typedef struct packed {
        logic clk;
        logic rst;
    } Data_Control_Control_T;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } arb_state_t;
endpackage

module mips_memory_arbiter
    import mips_memory_arbiter_pkg::*;
#(
    parameter int ADDR_L       = 64,
    parameter int ADDR_W       = $clog2(ADDR_L),
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  Data_Control_Control_T ctrl,
    input  logic                  iValid,
    input  logic [ADDR_W-1:0]     iAddr,
    output logic                  iReady,
    output logic                  iRvalid,
    output logic [31:0]           iRdata,
    input  logic                  dValid,
    input  logic                  dWrite,
    input  logic [ADDR_W-1:0]     dAddr,
    input  logic [31:0]           dWdata,
    output logic                  dReady,
    output logic                  dRvalid,
    output logic [31:0]           dRdata,
    output logic                  memEn,
    output logic                  memWe,
    output logic [ADDR_W-1:0]     memAddr,
    output logic [31:0]           memWdata,
    input  logic [31:0]           memRdata,
    output arb_state_t            dbg_state
);

    localparam int LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic clk;
    logic rst;
    assign clk = ctrl.clk;
    assign rst = ctrl.rst;

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [LAT_W-1:0]    lat;
    logic [LAT_W-1:0]    lat_nxt;
    logic [STARVE_W-1:0] starve;
    logic                fetch_win;
    logic                data_win;
    logic                own_fetch;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [31:0]         req_wdata;

    assign dbg_state = state;

    // Handshake: a request transfers in the cycle where valid & ready are
    // both high. Ready is only raised in IDLE (and never during reset), only
    // for the arbitration winner; requesters hold valid/addr/data until then.
    always_comb begin
        fetch_win = iValid && (!dValid || (starve >= STARVE_W'(STARVE_LIMIT)));
        data_win  = dValid && !fetch_win;
        iReady    = (state == S_IDLE) && !rst && fetch_win;
        dReady    = (state == S_IDLE) && !rst && data_win;
    end

    // Sequencer next state and memory strobe; the strobe is only live in ISSUE.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat;
        memEn     = 1'b0;
        memWe     = 1'b0;
        memAddr   = '0;
        memWdata  = '0;
        case (state)
            S_IDLE: begin
                if (iReady || dReady) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                memEn     = 1'b1;
                memWe     = req_we;
                memAddr   = req_addr;
                memWdata  = req_wdata;
                lat_nxt   = '0;
                state_nxt = (LATENCY == 1) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                if (lat == LAT_W'(LATENCY - 2)) state_nxt = S_CAPTURE;
                else lat_nxt = lat + LAT_W'(1);
            end
            S_CAPTURE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            lat   <= '0;
        end else begin
            state <= state_nxt;
            lat   <= lat_nxt;
        end
    end

    // Latch the granted request so the memory strobe is independent of the requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_fetch <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (iReady) begin
            own_fetch <= 1'b1;
            req_we    <= 1'b0;
            req_addr  <= iAddr;
            req_wdata <= '0;
        end else if (dReady) begin
            own_fetch <= 1'b0;
            req_we    <= dWrite;
            req_addr  <= dAddr;
            req_wdata <= dWdata;
        end
    end

    // Count cycles fetch is waiting without a grant; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
        end else if (!iValid || iReady) begin
            starve <= '0;
        end else if (starve < STARVE_W'(STARVE_LIMIT)) begin
            starve <= starve + STARVE_W'(1);
        end
    end

    // Capture read data for the owner and pulse its rvalid in the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iRvalid <= 1'b0;
            dRvalid <= 1'b0;
            iRdata  <= '0;
            dRdata  <= '0;
        end else begin
            iRvalid <= 1'b0;
            dRvalid <= 1'b0;
            if (state == S_CAPTURE) begin
                if (own_fetch) begin
                    iRdata  <= memRdata;
                    iRvalid <= 1'b1;
                end else begin
                    dRdata  <= req_we ? 32'd0 : memRdata;
                    dRvalid <= 1'b1;
                end
            end
        end
    end

endmodule
